// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer.
// MAIN drives the outputs and SKID catches the beat that arrives while MAIN is
// stalled. As a result, in_ready comes from a flop and never depends on out_ready.
// Flush squashes both slots and ctrl is zeroed on every bubble.
// A saturating counter records back-pressure cycles for performance debug.
module pipe_stage_skid #(
    parameter int unsigned CTRL_WIDTH       = 8,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter bit          CLEAR_DATA_FLUSH = 1'b0,
    parameter int unsigned STALL_CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_WIDTH-1:0]      in_ctrl,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_WIDTH-1:0]      out_ctrl,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [1:0]                 occupancy,
    output logic [STALL_CNT_WIDTH-1:0] stall_count
);

    // The encoding is the beat count, so occupancy is the state register itself.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CTRL_WIDTH-1:0]      main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0]      main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0]      skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0]      skid_data_q, skid_data_d;
    logic                       in_ready_q, in_ready_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       in_fire;
    logic                       main_valid;

    assign main_valid = (state_q != StEmpty);
    assign in_fire    = in_valid & in_ready_q;

    // Next-state, slot-steering and ready logic. Flush overrides every handshake event.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (CLEAR_DATA_FLUSH) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d     = StOne;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                StOne: begin
                    if (in_fire && out_ready) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = StFull;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_ready) begin
                        state_d     = StEmpty;
                    end
                end
                StFull: begin
                    if (out_ready) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end

        in_ready_d = (state_d != StFull);
    end

    // Saturating back-pressure counter; a flush cycle is not counted as a stall.
    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
    end

    // State and slot registers. Asynchronous reset drops any held beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid;
    assign out_ctrl    = main_valid ? main_ctrl_q : '0;
    assign out_data    = main_data_q;
    assign occupancy   = state_q;
    assign stall_count = stall_q;

endmodule
